// File: rtl/pulse_analyzer.sv
// rtl/pulse_analyzer.sv - threshold pulse detector measuring peak, width and decay shift
//
// Samples a signed pulse stream every clock. For each pulse that crosses
// THRESH it reports the peak amplitude, the time-over-threshold width and the
// decay shift that reproduces the first decay step, on a valid/ready port.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-high reset
//   din       in   W-bit signed sample, consumed every cycle
//   pk_amp    out  W-bit peak amplitude of the reported pulse
//   pk_sel    out  4-bit estimated decay shift
//   pk_err    out  no shift 0..15 reproduced the first decay step
//   pk_width  out  16-bit above-threshold sample count, saturating
//   pk_valid  out  result valid
//   pk_ready  in   consumer accepts the result
//   lost_cnt  out  8-bit saturating count of pulses missed while reporting

module pulse_analyzer #(
    parameter int W             = 14,
    parameter int signed THRESH = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic signed [W-1:0] din,
    output logic signed [W-1:0] pk_amp,
    output logic [3:0]          pk_sel,
    output logic                pk_err,
    output logic [15:0]         pk_width,
    output logic                pk_valid,
    input  logic                pk_ready,
    output logic [7:0]          lost_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PEAK,
        S_SEARCH,
        S_REPORT
    } state_t;

    localparam logic signed [W-1:0] THR = THRESH[W-1:0];

    state_t              state_q;
    logic signed [W-1:0] peak_q;
    logic [W:0]          drop_q;
    logic [3:0]          s_q;
    logic [15:0]         width_q;
    logic                tail_done_q;
    logic                search_done_q;
    logic [3:0]          res_sel_q;
    logic                res_err_q;
    logic                above_q;

    logic signed [W-1:0] pk_amp_q;
    logic [3:0]          pk_sel_q;
    logic                pk_err_q;
    logic [15:0]         pk_width_q;
    logic                pk_valid_q;
    logic [7:0]          lost_cnt_q;

    assign pk_amp   = pk_amp_q;
    assign pk_sel   = pk_sel_q;
    assign pk_err   = pk_err_q;
    assign pk_width = pk_width_q;
    assign pk_valid = pk_valid_q;
    assign lost_cnt = lost_cnt_q;

    logic              above;
    logic [W:0]        drop_d;
    logic signed [31:0] cand_sum;
    logic signed [31:0] cand;
    logic [31:0]       drop_ext;
    logic              search_hit;
    logic              done_now;
    logic              tail_now;
    logic [3:0]        sel_now;
    logic              err_now;
    logic [15:0]       width_inc;

    always_comb begin
        above     = (din > THR);
        drop_d    = {peak_q[W-1], peak_q} - {din[W-1], din};
        // Candidate is formed in 32 bits so that 1 << 15 cannot wrap; for any
        // positive peak it is then at least 1 and a zero drop never matches.
        cand_sum  = 32'(peak_q) + (32'sd1 <<< s_q);
        cand      = cand_sum >>> s_q;
        drop_ext  = {{(31 - W){1'b0}}, drop_q};
        search_hit = (cand == $signed(drop_ext));
        done_now  = search_done_q | search_hit | (s_q == 4'd15);
        sel_now   = search_done_q ? res_sel_q : s_q;
        err_now   = search_done_q ? res_err_q : ~search_hit;
        // The current sample can end the tail in the same cycle the search ends.
        tail_now  = tail_done_q | ~above;
        width_inc = (width_q == 16'hFFFF) ? width_q : width_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            peak_q        <= '0;
            drop_q        <= '0;
            s_q           <= '0;
            width_q       <= '0;
            tail_done_q   <= 1'b0;
            search_done_q <= 1'b0;
            res_sel_q     <= '0;
            res_err_q     <= 1'b0;
            above_q       <= 1'b0;
            pk_amp_q      <= '0;
            pk_sel_q      <= '0;
            pk_err_q      <= 1'b0;
            pk_width_q    <= '0;
            pk_valid_q    <= 1'b0;
            lost_cnt_q    <= '0;
        end else begin
            above_q <= above;
            case (state_q)
                S_IDLE: begin
                    if (above) begin
                        peak_q        <= din;
                        width_q       <= 16'd1;
                        tail_done_q   <= 1'b0;
                        search_done_q <= 1'b0;
                        state_q       <= S_PEAK;
                    end
                end

                S_PEAK: begin
                    if (!tail_done_q) begin
                        if (above) width_q <= width_inc;
                        else       tail_done_q <= 1'b1;
                    end
                    if (din > peak_q) begin
                        peak_q <= din;
                    end else begin
                        drop_q        <= drop_d;
                        s_q           <= '0;
                        search_done_q <= 1'b0;
                        state_q       <= S_SEARCH;
                    end
                end

                S_SEARCH: begin
                    if (!tail_done_q) begin
                        if (above) width_q <= width_inc;
                        else       tail_done_q <= 1'b1;
                    end
                    // Result is held internally until the tail ends; the
                    // outputs only change on entry to REPORT.
                    if (!search_done_q) begin
                        if (search_hit) begin
                            res_sel_q     <= s_q;
                            res_err_q     <= 1'b0;
                            search_done_q <= 1'b1;
                        end else if (s_q == 4'd15) begin
                            res_sel_q     <= 4'd15;
                            res_err_q     <= 1'b1;
                            search_done_q <= 1'b1;
                        end else begin
                            s_q <= s_q + 4'd1;
                        end
                    end
                    if (done_now && tail_now) begin
                        pk_amp_q   <= peak_q;
                        pk_width_q <= width_q;
                        pk_sel_q   <= sel_now;
                        pk_err_q   <= err_now;
                        pk_valid_q <= 1'b1;
                        state_q    <= S_REPORT;
                    end
                end

                S_REPORT: begin
                    if (above && !above_q && lost_cnt_q != 8'hFF) begin
                        lost_cnt_q <= lost_cnt_q + 8'd1;
                    end
                    if (pk_ready) begin
                        pk_valid_q <= 1'b0;
                        state_q    <= S_IDLE;
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_analyzer.sv
// tb/tb_pulse_analyzer.sv - scoreboard bench for pulse_analyzer

module tb_pulse_analyzer;

    logic               clk;
    logic               rst;
    logic signed [13:0] din;
    logic signed [13:0] pk_amp;
    logic [3:0]         pk_sel;
    logic               pk_err;
    logic [15:0]        pk_width;
    logic               pk_valid;
    logic               pk_ready;
    logic [7:0]         lost_cnt;

    pulse_analyzer #(.W(14), .THRESH(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .pk_amp   (pk_amp),
        .pk_sel   (pk_sel),
        .pk_err   (pk_err),
        .pk_width (pk_width),
        .pk_valid (pk_valid),
        .pk_ready (pk_ready),
        .lost_cnt (lost_cnt)
    );

    typedef struct {
        int amp;
        int sel;
        int err;
        int width;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int v);
        din = 14'(v);
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int amp, input int sel, input int err, input int width, input int c);
        exp_t e;
        e.amp = amp; e.sel = sel; e.err = err; e.width = width; e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            step(0);
            n++;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    // Monitor: pops one expectation per handshake and checks output stability
    // across stalled cycles.
    logic               prev_valid = 1'b0;
    logic               prev_ready = 1'b0;
    logic signed [13:0] prev_amp;
    logic [3:0]         prev_sel;
    logic               prev_err;
    logic [15:0]        prev_width;

    always @(negedge clk) begin
        if (!rst) begin
            if (pk_valid && prev_valid && !prev_ready) begin
                check("stable_amp", int'(pk_amp), int'(prev_amp));
                check("stable_w", int'(pk_width), int'(prev_width));
                check("stable_se", int'({pk_sel, pk_err}), int'({prev_sel, prev_err}));
            end
            if (pk_valid && pk_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("pk_amp", int'(pk_amp), e.amp);
                    check("pk_sel", int'(pk_sel), e.sel);
                    check("pk_err", int'(pk_err), e.err);
                    check("pk_width", int'(pk_width), e.width);
                    if (e.cyc >= 0) check("valid_cycle", cyc, e.cyc);
                end
            end
        end
        prev_valid = pk_valid;
        prev_ready = pk_ready;
        prev_amp   = pk_amp;
        prev_sel   = pk_sel;
        prev_err   = pk_err;
        prev_width = pk_width;
    end

    initial begin
        int gen[$];
        int x;
        int w;
        int n;

        rst = 1'b1;
        din = '0;
        pk_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", int'(pk_valid), 0);
        check("rst_amp", int'(pk_amp), 0);
        check("rst_sel", int'(pk_sel), 0);
        check("rst_err", int'(pk_err), 0);
        check("rst_width", int'(pk_width), 0);
        check("rst_lost", int'(lost_cnt), 0);
        rst = 1'b0;
        step(0);
        step(0);

        // Immediate match, immediate tail end: valid after crossing edge + 2.
        step(500);
        n = cyc;
        push(500, 0, 0, 1, n + 2);
        step(-1);
        step(0);
        step(0);
        check("valid_one_cycle", int'(pk_valid), 0);
        drain();

        // Generator-style decay with shift 3.
        x = 1000;
        w = 0;
        for (int i = 0; i < 60; i++) begin
            gen.push_back(x);
            if (x > 16) w++;
            x = x - ((x + 8) >>> 3);
        end
        push(1000, 3, 0, w, -1);
        foreach (gen[i]) step(gen[i]);
        drain();

        // Plateau: zero drop never matches.
        push(300, 15, 1, 2, -1);
        step(300);
        step(300);
        step(0);
        repeat (25) step(0);
        drain();

        // Stalled consumer while three more pulses arrive.
        pk_ready = 1'b0;
        push(500, 0, 0, 1, -1);
        step(500);
        step(-1);
        repeat (4) step(0);
        for (int k = 0; k < 3; k++) begin
            step(200);
            repeat (3) step(0);
        end
        repeat (32) step(0);
        check("lost_after_stall", int'(lost_cnt), 3);
        check("valid_held", int'(pk_valid), 1);
        pk_ready = 1'b1;
        drain();
        step(0);
        check("lost_persist", int'(lost_cnt), 3);
        push(800, 2, 0, 2, -1);
        step(800);
        step(599);
        step(0);
        drain();

        // Reset during SEARCH aborts the pulse.
        step(120);
        step(100);
        step(100);
        step(100);
        rst = 1'b1;
        #1;
        check("rst_mid_valid", int'(pk_valid), 0);
        check("rst_mid_lost", int'(lost_cnt), 0);
        check("rst_mid_width", int'(pk_width), 0);
        din = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(0);
        step(500);
        n = cyc;
        push(500, 0, 0, 1, n + 2);
        step(-1);
        step(0);
        drain();

        // Width saturation over a long plateau below the peak.
        push(120, 15, 1, 65535, -1);
        step(120);
        for (int i = 0; i < 70000; i++) step(100);
        check("sat_no_valid", int'(pk_valid), 0);
        step(0);
        drain();

        repeat (5) step(0);
        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
